triangle_assembler: RTL and testbench

//  Downstream neighbour of the obstacle-to-triangle converter. Collects its per-vertex

---
 rtl/triangle_assembler.sv | 134 +++++++++++++
 tb/tb_triangle_assembler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_assembler.sv
// Triangle assembler: gathers a per-vertex stream into 3-vertex triangles, culls
// degenerate ones and queues the rest in a show-ahead FIFO for the rasteriser.
module triangle_assembler #(
  parameter int DEPTH      = 8,
  parameter bit CULL_DEGEN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [47:0]  vertex,
  input  logic [15:0]  color,
  input  logic         new_triangle,
  input  logic         vertex_valid,
  output logic         vertex_ready,
  input  logic         done_in,
  output logic [143:0] tri_data,
  output logic [15:0]  tri_color,
  output logic         tri_valid,
  input  logic         tri_ready,
  output logic         done_out,
  output logic         proto_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    VC_0 = 2'd0,
    VC_1 = 2'd1,
    VC_2 = 2'd2
  } vcnt_t;

  vcnt_t         vcnt;
  vcnt_t         vcnt_eff;
  logic [47:0]   v0_q;
  logic [47:0]   v1_q;
  logic [15:0]   color_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          done_pend;
  logic [143:0]  data_mem  [DEPTH];
  logic [15:0]   color_mem [DEPTH];

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;
  logic degen;

  // Handshake (both ports): a transfer happens in exactly the cycles where valid and
  // ready are both high; ready never depends on valid, and the producer must hold its
  // payload stable until the transfer happens.
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign accept = vertex_valid && vertex_ready;
  assign pop    = tri_valid && tri_ready;

  // A vertex arriving with done_in belongs to the next frame, so it sees an empty partial.
  assign vcnt_eff = done_in ? VC_0 : vcnt;

  assign degen = CULL_DEGEN && ((v0_q == v1_q) || (v1_q == vertex) || (v0_q == vertex));
  assign push  = accept && !new_triangle && (vcnt_eff == VC_2) && !degen;

  assign vertex_ready = !full;
  assign tri_valid    = !empty;
  assign tri_data     = empty ? '0 : data_mem[rd_ptr];
  assign tri_color    = empty ? '0 : color_mem[rd_ptr];
  assign done_out     = done_pend && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcnt      <= VC_0;
      v0_q      <= '0;
      v1_q      <= '0;
      color_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done_pend <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (done_in && (vcnt != VC_0)) begin
        proto_err <= 1'b1;
      end

      if (accept) begin
        if (new_triangle) begin
          v0_q    <= vertex;
          color_q <= color;
          vcnt    <= VC_1;
          if (vcnt_eff != VC_0) begin
            proto_err <= 1'b1;
          end
        end else begin
          case (vcnt_eff)
            VC_0: begin
              vcnt      <= VC_0;
              proto_err <= 1'b1;
            end
            VC_1: begin
              v1_q <= vertex;
              vcnt <= VC_2;
            end
            default: vcnt <= VC_0;
          endcase
        end
      end else if (done_in) begin
        vcnt <= VC_0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      // Repeated done_in while a pulse is still owed merges into that single pulse.
      done_pend <= done_out ? 1'b0 : (done_pend || done_in);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= {v0_q, v1_q, vertex};
      color_mem[wr_ptr] <= color_q;
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: directed scenarios then random traffic, all checked
// against a queue-based model of the assembler and its triangle FIFO.
module tb_triangle_assembler;
  localparam int DEPTH = 8;

  logic         clk          = 1'b0;
  logic         rst          = 1'b0;
  logic [47:0]  vertex       = '0;
  logic [15:0]  color        = '0;
  logic         new_triangle = 1'b0;
  logic         vertex_valid = 1'b0;
  logic         done_in      = 1'b0;
  logic         tri_ready    = 1'b0;

  logic         vertex_ready;
  logic [143:0] tri_data;
  logic [15:0]  tri_color;
  logic         tri_valid;
  logic         done_out;
  logic         proto_err;

  logic         nc_vertex_ready;
  logic [143:0] nc_tri_data;
  logic [15:0]  nc_tri_color;
  logic         nc_tri_valid;
  logic         nc_done_out;
  logic         nc_proto_err;

  triangle_assembler #(.DEPTH(DEPTH), .CULL_DEGEN(1'b1)) dut (
    .clk(clk), .rst(rst), .vertex(vertex), .color(color), .new_triangle(new_triangle),
    .vertex_valid(vertex_valid), .vertex_ready(vertex_ready), .done_in(done_in),
    .tri_data(tri_data), .tri_color(tri_color), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .done_out(done_out), .proto_err(proto_err)
  );

  triangle_assembler #(.DEPTH(DEPTH), .CULL_DEGEN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .vertex(vertex), .color(color), .new_triangle(new_triangle),
    .vertex_valid(vertex_valid), .vertex_ready(nc_vertex_ready), .done_in(done_in),
    .tri_data(nc_tri_data), .tri_color(nc_tri_color), .tri_valid(nc_tri_valid),
    .tri_ready(tri_ready), .done_out(nc_done_out), .proto_err(nc_proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state: queued triangles {v0,v1,v2,colour}, the partial triangle,
  // the owed done pulse and the sticky error flag
  int           n_checks  = 0;
  int           n_fail    = 0;
  int           done_seen = 0;
  logic [159:0] exp_q[$];
  logic [47:0]  part_q[$];
  logic [15:0]  part_color  = '0;
  logic         m_done_pend = 1'b0;
  logic         m_err       = 1'b0;

  function automatic logic [47:0] mk(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [159:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({tag, ":vertex_ready"}, vertex_ready, exp_q.size() < DEPTH);
    chk({tag, ":tri_valid"}, tri_valid, exp_q.size() != 0);
    chk({tag, ":tri_data"}, tri_data, head[159:16]);
    chk({tag, ":tri_color"}, tri_color, head[15:0]);
    chk({tag, ":done_out"}, done_out, m_done_pend && (exp_q.size() == 0));
    chk({tag, ":proto_err"}, proto_err, m_err);
  endtask

  // driver: one clock cycle of stimulus, checked and then applied to the model
  task automatic drive(input logic vv, input logic nt, input logic [47:0] vtx,
                       input logic [15:0] col, input logic din, input logic trdy,
                       output logic accepted);
    logic fire;
    vertex_valid = vv;
    new_triangle = nt;
    vertex       = vtx;
    color        = col;
    done_in      = din;
    tri_ready    = trdy;
    check_outputs("cycle");
    if (done_out === 1'b1) done_seen++;
    fire     = m_done_pend && (exp_q.size() == 0);
    accepted = vv && (exp_q.size() < DEPTH);
    if (trdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (din && part_q.size() != 0) begin
      m_err = 1'b1;
      part_q.delete();
    end
    if (accepted) begin
      if (nt) begin
        if (part_q.size() != 0) m_err = 1'b1;
        part_q.delete();
        part_q.push_back(vtx);
        part_color = col;
      end else if (part_q.size() == 0) begin
        m_err = 1'b1;
      end else begin
        part_q.push_back(vtx);
        if (part_q.size() == 3) begin
          if (!(part_q[0] == part_q[1] || part_q[1] == part_q[2] || part_q[0] == part_q[2]))
            exp_q.push_back({part_q[0], part_q[1], part_q[2], part_color});
          part_q.delete();
        end
      end
    end
    m_done_pend = fire ? 1'b0 : (m_done_pend || din);
    @(posedge clk);
    #1;
  endtask

  task automatic send_vertex(input logic nt, input logic [47:0] vtx, input logic [15:0] col,
                             input logic trdy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) drive(1'b1, nt, vtx, col, 1'b0, trdy, acc);
    if (!acc) begin
      n_fail++;
      $display("FAIL send_vertex timeout vertex=%0h", vtx);
    end
  endtask

  task automatic idle(input int n, input logic trdy);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, trdy, acc);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    vertex_valid = 1'b0;
    new_triangle = 1'b0;
    done_in      = 1'b0;
    tri_ready    = 1'b0;
    vertex       = '0;
    color        = '0;
    #1;
    exp_q.delete();
    part_q.delete();
    m_done_pend = 1'b0;
    m_err       = 1'b0;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic [47:0] va, vb, vc;
    int          pos;

    #2;
    do_reset();

    // 1: single triangle, one-cycle latency, popped immediately
    va = mk(10, 20, 30);
    vb = mk(-5, 40, 7);
    vc = mk(100, -100, 0);
    send_vertex(1'b1, va, 16'hF800, 1'b1);
    send_vertex(1'b0, vb, 16'h0000, 1'b1);
    send_vertex(1'b0, vc, 16'h0000, 1'b1);
    chk("t1_valid", tri_valid, 1'b1);
    chk("t1_data", tri_data, {va, vb, vc});
    chk("t1_color", tri_color, 16'hF800);
    idle(2, 1'b1);
    chk("t1_popped", tri_valid, 1'b0);

    // 2: fill the FIFO, stall the ninth triangle, then drain in order
    do_reset();
    for (int t = 0; t < 8; t++) begin
      send_vertex(1'b1, mk(t, 1, 2), 16'(t * 3 + 1), 1'b0);
      send_vertex(1'b0, mk(t, 3, 4), 16'h0000, 1'b0);
      send_vertex(1'b0, mk(t, 5, 6), 16'h0000, 1'b0);
    end
    chk("t2_full_ready", vertex_ready, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, mk(8, 1, 2), 16'h0123, 1'b0, 1'b0, acc);
    chk("t2_still_full", vertex_ready, 1'b0);
    send_vertex(1'b1, mk(8, 1, 2), 16'h0123, 1'b1);
    send_vertex(1'b0, mk(8, 3, 4), 16'h0000, 1'b1);
    send_vertex(1'b0, mk(8, 5, 6), 16'h0000, 1'b1);
    idle(12, 1'b1);
    chk("t2_drained", tri_valid, 1'b0);

    // 3: degenerate triangle culled vs kept
    do_reset();
    send_vertex(1'b1, mk(1, 2, 3), 16'h07E0, 1'b0);
    send_vertex(1'b0, mk(1, 2, 3), 16'h0000, 1'b0);
    send_vertex(1'b0, mk(4, 5, 6), 16'h0000, 1'b0);
    chk("t3_cull_valid", tri_valid, 1'b0);
    chk("t3_keep_valid", nc_tri_valid, 1'b1);
    chk("t3_keep_data", nc_tri_data, {mk(1, 2, 3), mk(1, 2, 3), mk(4, 5, 6)});
    chk("t3_keep_color", nc_tri_color, 16'h07E0);
    chk("t3_keep_ready", nc_vertex_ready, 1'b1);
    chk("t3_keep_err", nc_proto_err, 1'b0);
    chk("t3_keep_done", nc_done_out, 1'b0);
    idle(2, 1'b1);
    chk("t3_keep_popped", nc_tri_valid, 1'b0);

    // 4: protocol violations
    do_reset();
    send_vertex(1'b0, mk(5, 5, 5), 16'h0000, 1'b1);
    chk("t4_orphan_err", proto_err, 1'b1);
    do_reset();
    send_vertex(1'b1, mk(7, 7, 7), 16'h001F, 1'b1);
    send_vertex(1'b0, mk(8, 8, 8), 16'h0000, 1'b1);
    send_vertex(1'b1, mk(9, 1, 1), 16'hAAAA, 1'b1);
    chk("t4_restart_err", proto_err, 1'b1);
    send_vertex(1'b0, mk(9, 2, 2), 16'h0000, 1'b1);
    send_vertex(1'b0, mk(9, 3, 3), 16'h0000, 1'b1);
    chk("t4_data", tri_data, {mk(9, 1, 1), mk(9, 2, 2), mk(9, 3, 3)});
    chk("t4_color", tri_color, 16'hAAAA);
    send_vertex(1'b0, mk(5, 5, 5), 16'h0000, 1'b1);
    idle(2, 1'b1);
    chk("t4_err_sticky", proto_err, 1'b1);

    // 5: done held until the queue drains; done with empty queue
    do_reset();
    done_seen = 0;
    for (int t = 0; t < 2; t++) begin
      send_vertex(1'b1, mk(t, 0, 0), 16'h1111, 1'b0);
      send_vertex(1'b0, mk(t, 1, 0), 16'h0000, 1'b0);
      send_vertex(1'b0, mk(t, 2, 0), 16'h0000, 1'b0);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    idle(4, 1'b0);
    chk("t5_hold", done_seen, 0);
    idle(6, 1'b1);
    chk("t5_one_pulse", done_seen, 1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);
    chk("t5_empty_pulse", done_seen, 2);
    chk("t5_no_err", proto_err, 1'b0);

    // 6: reset mid-triangle with a queued triangle
    do_reset();
    send_vertex(1'b1, mk(3, 3, 1), 16'h00FF, 1'b0);
    send_vertex(1'b0, mk(3, 3, 2), 16'h0000, 1'b0);
    send_vertex(1'b0, mk(3, 3, 3), 16'h0000, 1'b0);
    send_vertex(1'b1, mk(4, 4, 1), 16'h0F0F, 1'b0);
    chk("t6_queued", tri_valid, 1'b1);
    do_reset();
    send_vertex(1'b0 | 1'b1, mk(6, 1, 1), 16'hBEEF, 1'b0);
    send_vertex(1'b0, mk(6, 2, 2), 16'h0000, 1'b0);
    send_vertex(1'b0, mk(6, 3, 3), 16'h0000, 1'b0);
    chk("t6_data", tri_data, {mk(6, 1, 1), mk(6, 2, 2), mk(6, 3, 3)});
    chk("t6_color", tri_color, 16'hBEEF);
    idle(2, 1'b1);

    // random traffic: mostly well-formed stream with occasional errors and done pulses
    do_reset();
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      logic        vv, nt, din;
      logic [47:0] v;
      vv  = ($urandom_range(0, 9) < 7);
      nt  = (pos == 0);
      if ($urandom_range(0, 24) == 0) nt = !nt;
      din = ($urandom_range(0, 39) == 0);
      v   = mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
      drive(vv, nt, v, 16'($urandom), din, ($urandom_range(0, 2) != 0), acc);
      if (din) pos = 0;
      if (acc) begin
        if (nt) pos = 1;
        else if (pos != 0) pos = (pos + 1) % 3;
      end
    end
    idle(20, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
